seq_detect_param: RTL and testbench

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_param.sv | 101 ++++++++++
 tb/tb_seq_detect_param.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with runtime-loadable pattern,
// overlapping/non-overlapping match modes and a saturating match counter.
module seq_detect_param #(
    parameter int             N       = 7,
    parameter logic [N-1:0]   PATTERN = 7'b0101010,
    parameter int             OVERLAP = 1,
    parameter int             CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cfg_load,
    input  logic [N-1:0]     cfg_pattern,
    input  logic             clr_count,
    output logic             flag,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int             FW        = $clog2(N + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N-1:0]     pat_r,   pat_nxt_s;
    logic [N-1:0]     hist_r,  hist_nxt_s, hist_shift_s;
    logic [FW-1:0]    fill_r,  fill_nxt_s, fill_inc_s;
    logic             flag_r;
    logic             match_s;
    logic [CNT_W-1:0] count_r, count_nxt_s;
    logic             sat_r,   sat_nxt_s;

    // Pattern, history and fill update; detects a match on the accepted bit.
    always_comb begin
        pat_nxt_s    = pat_r;
        hist_nxt_s   = hist_r;
        fill_nxt_s   = fill_r;
        match_s      = 1'b0;
        hist_shift_s = {hist_r[N-2:0], din};
        fill_inc_s   = (fill_r == FILL_FULL) ? FILL_FULL : fill_r + FW'(1);
        if (cfg_load) begin
            pat_nxt_s  = cfg_pattern;
            hist_nxt_s = {N{1'b0}};
            fill_nxt_s = {FW{1'b0}};
        end else if (din_valid) begin
            hist_nxt_s = hist_shift_s;
            match_s    = (fill_inc_s == FILL_FULL) && (hist_shift_s == pat_r);
            // Non-overlapping mode restarts the window so no matched bit is reused
            if (match_s && (OVERLAP == 0)) begin
                fill_nxt_s = {FW{1'b0}};
            end else begin
                fill_nxt_s = fill_inc_s;
            end
        end else begin
            hist_nxt_s = hist_r;
            fill_nxt_s = fill_r;
        end
    end

    // Saturating match counter with sticky saturation flag; clear wins but still counts a same-edge match.
    always_comb begin
        count_nxt_s = count_r;
        sat_nxt_s   = sat_r;
        if (clr_count) begin
            count_nxt_s = match_s ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}};
            sat_nxt_s   = 1'b0;
        end else if (match_s) begin
            if (count_r == CNT_MAX) begin
                sat_nxt_s = 1'b1;
            end else begin
                count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r   <= PATTERN;
            hist_r  <= {N{1'b0}};
            fill_r  <= {FW{1'b0}};
            flag_r  <= 1'b0;
            count_r <= {CNT_W{1'b0}};
            sat_r   <= 1'b0;
        end else begin
            pat_r   <= pat_nxt_s;
            hist_r  <= hist_nxt_s;
            fill_r  <= fill_nxt_s;
            flag_r  <= match_s;
            count_r <= count_nxt_s;
            sat_r   <= sat_nxt_s;
        end
    end

    assign flag        = flag_r;
    assign match_count = count_r;
    assign count_sat   = sat_r;

endmodule

// File: tb/tb_seq_detect_param.sv
// Self-checking bench: three detector variants share one stimulus stream and
// are compared every cycle against a log-of-accepted-bits reference model.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, din, din_valid, cfg_load, clr_count;
    logic [6:0] cfg_pattern;

    logic       flag_a, flag_b, flag_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       sat_a, sat_b, sat_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.N(7), .PATTERN(7'b0101010), .OVERLAP(1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .clr_count(clr_count),
        .flag(flag_a), .match_count(cnt_a), .count_sat(sat_a));

    seq_detect_param #(.N(7), .PATTERN(7'b0101010), .OVERLAP(0), .CNT_W(8)) u_no (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .clr_count(clr_count),
        .flag(flag_b), .match_count(cnt_b), .count_sat(sat_b));

    seq_detect_param #(.N(7), .PATTERN(7'b0101010), .OVERLAP(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .clr_count(clr_count),
        .flag(flag_c), .match_count(cnt_c), .count_sat(sat_c));

    // Reference model: every accepted bit is logged; each variant remembers
    // where its current detection window starts in that log.
    bit         acc_log[$];
    int         win_start [3];
    logic [6:0] mpat [3];
    int         mcount [3];
    bit         msat [3];
    bit         mflag [3];
    bit         overlap_of [3] = '{1'b1, 1'b0, 1'b1};
    int         cmax_of [3]    = '{255, 255, 3};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] last7();
        logic [6:0] w;
        int sz;
        sz = acc_log.size();
        for (int k = 0; k < 7; k++) w[6-k] = acc_log[sz-7+k];
        return w;
    endfunction

    task automatic model_edge(input bit r, input bit dv, input bit d,
                              input bit cl, input logic [6:0] cp, input bit clr);
        bit m;
        if (!r && !cl && dv) acc_log.push_back(d);
        for (int i = 0; i < 3; i++) begin
            m = 1'b0;
            if (r) begin
                mpat[i] = 7'b0101010;
                win_start[i] = acc_log.size();
                mcount[i] = 0;
                msat[i] = 1'b0;
            end else begin
                if (cl) begin
                    mpat[i] = cp;
                    win_start[i] = acc_log.size();
                end else if (dv) begin
                    if ((acc_log.size() - win_start[i] >= 7) && (last7() == mpat[i])) begin
                        m = 1'b1;
                        if (!overlap_of[i]) win_start[i] = acc_log.size();
                    end
                end
                if (clr) begin
                    mcount[i] = m ? 1 : 0;
                    msat[i] = 1'b0;
                end else if (m) begin
                    if (mcount[i] == cmax_of[i]) msat[i] = 1'b1;
                    else mcount[i] = mcount[i] + 1;
                end
            end
            mflag[i] = m;
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare all outputs.
    task automatic step(input bit r, input bit dv, input bit d,
                        input bit cl, input logic [6:0] cp, input bit clr);
        rst = r; din_valid = dv; din = d; cfg_load = cl; cfg_pattern = cp; clr_count = clr;
        @(posedge clk);
        model_edge(r, dv, d, cl, cp, clr);
        #1;
        chk("flag_ov",  int'(flag_a), int'(mflag[0]));
        chk("count_ov", int'(cnt_a),  mcount[0]);
        chk("sat_ov",   int'(sat_a),  int'(msat[0]));
        chk("flag_no",  int'(flag_b), int'(mflag[1]));
        chk("count_no", int'(cnt_b),  mcount[1]);
        chk("sat_no",   int'(sat_b),  int'(msat[1]));
        chk("flag_c2",  int'(flag_c), int'(mflag[2]));
        chk("count_c2", int'(cnt_c),  mcount[2]);
        chk("sat_c2",   int'(sat_c),  int'(msat[2]));
    endtask

    task automatic bit_in(input bit d);
        step(1'b0, 1'b1, d, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic reset_cycle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    endtask

    task automatic feed(input logic [6:0] p);
        for (int k = 6; k >= 0; k--) bit_in(p[k]);
    endtask

    initial begin
        logic [6:0] rp;
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 7'd0; clr_count = 1'b0;

        // Reset state
        reset_cycle();
        chk("lit_reset_flag",  int'(flag_a), 0);
        chk("lit_reset_count", int'(cnt_a), 0);
        chk("lit_reset_sat",   int'(sat_c), 0);

        // Basic match, then overlapping vs non-overlapping continuation
        feed(7'b0101010);
        chk("lit_first_flag",  int'(flag_a), 1);
        chk("lit_first_count", int'(cnt_a), 1);
        bit_in(1'b1);
        chk("lit_mid_flag", int'(flag_a), 0);
        bit_in(1'b0);
        chk("lit_ov_flag2",  int'(flag_a), 1);
        chk("lit_ov_count2", int'(cnt_a), 2);
        chk("lit_no_flag2",  int'(flag_b), 0);
        chk("lit_no_count2", int'(cnt_b), 1);

        // Idle gaps do not break a partial sequence
        reset_cycle();
        bit_in(1'b0); idle(); bit_in(1'b1); idle(); idle();
        bit_in(1'b0); idle(); bit_in(1'b1); idle();
        bit_in(1'b0); bit_in(1'b1); bit_in(1'b0);
        chk("lit_gap_flag", int'(flag_a), 1);

        // Pattern load discards the coincident bit
        reset_cycle();
        step(1'b0, 1'b1, 1'b1, 1'b1, 7'b1110001, 1'b0);
        feed(7'b1110001);
        chk("lit_cfg_flag", int'(flag_a), 1);
        feed(7'b0101010);
        chk("lit_old_pat_flag", int'(flag_a), 0);

        // Saturation on the 2-bit counter, then clear on a match edge
        reset_cycle();
        feed(7'b0101010);
        for (int k = 0; k < 3; k++) begin
            bit_in(1'b1); bit_in(1'b0);
        end
        chk("lit_sat_count", int'(cnt_c), 3);
        chk("lit_sat_flag",  int'(sat_c), 1);
        idle();
        chk("lit_sat_hold", int'(sat_c), 1);
        bit_in(1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
        chk("lit_clr_count", int'(cnt_c), 1);
        chk("lit_clr_sat",   int'(sat_c), 0);

        // Reset discards a partial sequence
        reset_cycle();
        for (int k = 0; k < 3; k++) begin
            bit_in(1'b0); bit_in(1'b1);
        end
        reset_cycle();
        bit_in(1'b0);
        chk("lit_rst_partial", int'(flag_a), 0);
        for (int k = 0; k < 3; k++) begin
            bit_in(1'b1); bit_in(1'b0);
        end
        chk("lit_rst_full", int'(flag_a), 1);

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            rp = ($urandom_range(0, 1) == 0) ? 7'b0101010 : 7'($urandom);
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) < 7),
                 1'($urandom),
                 ($urandom_range(0, 99) < 2),
                 rp,
                 ($urandom_range(0, 99) < 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
